// File: rtl/spike_fifo_arbiter.sv
// Round-robin arbiter sharing one spike address FIFO between sources.
// Optional stall statistic built when SPIKE_ARB_STATS_EN is defined.
module spike_fifo_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int ID_W       = 2,
    parameter int LOCAL_AW   = 12,
    parameter int FIFO_DEPTH = 128,
    parameter int OCC_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          i_req,
    input  logic [NUM_SRC*LOCAL_AW-1:0] i_addr,
    output logic [NUM_SRC-1:0]          o_gnt,
    output logic                        o_fifo_wr_en,
    output logic [ID_W+LOCAL_AW-1:0]    o_fifo_wdata,
    input  logic                        i_fifo_rd_en,
    input  logic                        i_fifo_valid,
    output logic [OCC_W-1:0]            o_occupancy,
    output logic                        o_full,
    input  logic                        i_flush,
    output logic                        o_busy,
    output logic                        o_flush_done,
    output logic [15:0]                 o_stall_cnt
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [OCC_W-1:0]  occ;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   win;
    logic              found;
    logic              gnt_en;
    logic              pop;
    logic              wr;

    assign o_occupancy = occ;
    assign o_full      = (occ == OCC_W'(FIFO_DEPTH));
    assign pop         = i_fifo_rd_en && i_fifo_valid;

    // A read of an empty FIFO makes it discard the write, so hold off.
    assign gnt_en = !rst && (state == RUN) && !o_full &&
                    !(i_fifo_rd_en && !i_fifo_valid);

    // Scan requests starting just after the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = ptr + ID_W'(i);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign wr           = gnt_en && found;
    assign o_fifo_wr_en = wr;
    assign o_gnt        = wr ? (NUM_SRC'(1) << win) : '0;
    assign o_fifo_wdata = {win, i_addr[win*LOCAL_AW +: LOCAL_AW]};

    // Remember the last granted source for round-robin fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_W'(NUM_SRC - 1);
        end else if (wr) begin
            ptr <= win;
        end
    end

    // Credit counter mirroring FIFO fill level; never wraps below 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (wr && !pop) begin
            occ <= occ + 1'b1;
        end else if (pop && !wr && occ != '0) begin
            occ <= occ - 1'b1;
        end
    end

    // Flush sequencer: stop granting, wait for empty, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            o_busy       <= 1'b0;
            o_flush_done <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (i_flush) begin
                        if (occ == '0) begin
                            state        <= DONE;
                            o_flush_done <= 1'b1;
                        end else begin
                            state  <= DRAIN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (occ == '0) begin
                        state        <= DONE;
                        o_busy       <= 1'b0;
                        o_flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= RUN;
                    o_flush_done <= 1'b0;
                end
                default: begin
                    state        <= RUN;
                    o_busy       <= 1'b0;
                    o_flush_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPIKE_ARB_STATS_EN
    logic [15:0] stall_q;

    assign o_stall_cnt = stall_q;

    // Count backpressure cycles; cleared when a flush completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state == DONE) begin
            stall_q <= '0;
        end else if (state == RUN && |i_req && !wr &&
                     stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// Directed self-checking bench for spike_fifo_arbiter.
module tb_spike_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_req;
    logic [47:0] i_addr;
    logic [3:0]  o_gnt;
    logic        o_fifo_wr_en;
    logic [13:0] o_fifo_wdata;
    logic        i_fifo_rd_en;
    logic        i_fifo_valid;
    logic [7:0]  o_occupancy;
    logic        o_full;
    logic        i_flush;
    logic        o_busy;
    logic        o_flush_done;
    logic [15:0] o_stall_cnt;

    int checks = 0;
    int errors = 0;

    spike_fifo_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .o_gnt        (o_gnt),
        .o_fifo_wr_en (o_fifo_wr_en),
        .o_fifo_wdata (o_fifo_wdata),
        .i_fifo_rd_en (i_fifo_rd_en),
        .i_fifo_valid (i_fifo_valid),
        .o_occupancy  (o_occupancy),
        .o_full       (o_full),
        .i_flush      (i_flush),
        .o_busy       (o_busy),
        .o_flush_done (o_flush_done),
        .o_stall_cnt  (o_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst          = 1'b1;
        i_req        = 4'b0001;
        i_addr       = '0;
        i_fifo_rd_en = 1'b0;
        i_fifo_valid = 1'b0;
        i_flush      = 1'b0;
        #2;
        check("rst_gnt", o_gnt, 4'b0000);
        check("rst_wr", o_fifo_wr_en, 0);
        check("rst_occ", o_occupancy, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_flush_done, 0);
        check("rst_stall", o_stall_cnt, 0);
        step();
        rst = 1'b0;
        i_req = 4'b0001;
        i_addr[11:0] = 12'h123;
        settle();
        check("t1_gnt", o_gnt, 4'b0001);
        check("t1_wdata", o_fifo_wdata, 14'h0123);
        check("t1_wr", o_fifo_wr_en, 1);
        step();
        check("t1_occ", o_occupancy, 1);

        // Full contention round robin from reset.
        i_req = 4'b0000;
        do_reset();
        i_addr = {12'hA03, 12'hA02, 12'hA01, 12'hA00};
        i_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("rr_gnt", o_gnt, 32'd1 << (k % 4));
            check("rr_wdata", o_fifo_wdata,
                  ((k % 4) << 12) | (12'hA00 + (k % 4)));
            step();
        end
        check("rr_occ", o_occupancy, 8);

        // Fill up, then one pop frees exactly one slot.
        for (int k = 0; k < 120; k++) step();
        check("full_occ", o_occupancy, 128);
        check("full_flag", o_full, 1);
        check("full_gnt", o_gnt, 0);
        check("full_stall", o_stall_cnt, 0);
        i_fifo_rd_en = 1'b1;
        i_fifo_valid = 1'b1;
        settle();
        check("pop_gnt", o_gnt, 0);
        step();
        check("pop_occ", o_occupancy, 127);
        i_fifo_rd_en = 1'b0;
        settle();
        check("refill_gnt", o_gnt, 4'b0001);
        step();
        check("refill_occ", o_occupancy, 128);
        check("refill_full", o_full, 1);

        // Simultaneous write/pop and discarded-write guard.
        i_req = 4'b0000;
        i_fifo_valid = 1'b0;
        do_reset();
        i_req = 4'b0001;
        for (int k = 0; k < 5; k++) step();
        check("occ5", o_occupancy, 5);
        i_fifo_rd_en = 1'b1;
        i_fifo_valid = 1'b1;
        settle();
        check("wrpop_gnt", o_gnt, 4'b0001);
        step();
        check("wrpop_occ", o_occupancy, 5);
        i_fifo_valid = 1'b0;
        settle();
        check("rdempty_gnt", o_gnt, 0);
        check("rdempty_wr", o_fifo_wr_en, 0);
        step();
        check("rdempty_occ", o_occupancy, 5);
        i_fifo_rd_en = 1'b0;
        settle();
        check("after_gnt", o_gnt, 4'b0001);
        step();
        check("after_occ", o_occupancy, 6);

        // Flush with three entries queued, pointer left at source 1.
        i_req = 4'b0000;
        do_reset();
        i_req = 4'b0010;
        for (int k = 0; k < 3; k++) step();
        check("fl_occ", o_occupancy, 3);
        i_req = 4'b0000;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_req = 4'b1111;
        settle();
        check("fl_busy", o_busy, 1);
        check("fl_gnt", o_gnt, 0);
        i_fifo_rd_en = 1'b1;
        i_fifo_valid = 1'b1;
        for (int k = 0; k < 3; k++) step();
        i_fifo_rd_en = 1'b0;
        i_fifo_valid = 1'b0;
        settle();
        check("fl_occ0", o_occupancy, 0);
        check("fl_still_busy", o_busy, 1);
        check("fl_nodone", o_flush_done, 0);
        step();
        check("fl_done", o_flush_done, 1);
        check("fl_done_busy", o_busy, 0);
        check("fl_done_gnt", o_gnt, 0);
        step();
        check("fl_done_off", o_flush_done, 0);
        check("fl_resume", o_gnt, 4'b0100);

        // Flush while already empty goes straight to done.
        i_req = 4'b0000;
        do_reset();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        settle();
        check("fl0_done", o_flush_done, 1);
        check("fl0_busy", o_busy, 0);

        // Async reset in the middle of a drain.
        do_reset();
        i_req = 4'b0001;
        step();
        step();
        i_req = 4'b0000;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_req = 4'b1111;
        settle();
        check("rd_busy", o_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rd_busy0", o_busy, 0);
        check("rd_occ0", o_occupancy, 0);
        check("rd_gnt0", o_gnt, 0);
        step();
        rst = 1'b0;
        settle();
        check("rd_resume", o_gnt, 4'b0001);
        step();
        check("rd_occ1", o_occupancy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
